// File: rtl/serial_pkg.sv
// Shared definitions for the bit-paced serial link (receiver and transmitter).
package serial_pkg;

  localparam int unsigned SERIAL_BIT_CLKS  = 100;
  localparam int unsigned SERIAL_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_receiver_bit_phase_counter.sv
// Bit-period phase counter: counts 1..N while running, wraps N -> 1, clear forces 0.
module bit_phase_counter
  import serial_pkg::*;
#(
  parameter int unsigned N = SERIAL_BIT_CLKS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    run,
  output logic [$clog2(N+1)-1:0]  phase,
  output logic                    wrap
);

  localparam int unsigned PW = $clog2(N + 1);

  assign wrap = run && (phase == PW'(N));

  // Phase register: cleared to 0, otherwise advances and wraps back to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (run) begin
      phase <= wrap ? PW'(1) : phase + PW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, DATA_BITS data bits LSB first, one stop bit.
// Emits a one-cycle rx_valid with the recovered word, or frame_error on a low stop bit.
module serial_frame_receiver
  import serial_pkg::*;
#(
  parameter int unsigned BIT_CLKS     = SERIAL_BIT_CLKS,
  parameter int unsigned DATA_BITS    = SERIAL_DATA_BITS,
  parameter int unsigned SAMPLE_POINT = BIT_CLKS / 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(BIT_CLKS + 1);
  localparam int unsigned IW = idx_width(DATA_BITS);

  rx_state_t            state, state_nxt;
  logic                 rx_m, rx_s, rx_d;
  logic [2:0]           line_ok;
  logic [PW-1:0]        phase;
  logic                 wrap;
  logic                 clear, run;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 start_edge, sample, last_bit, stop_sample;

  // Two-flop synchroniser plus one cycle of history for the falling-edge detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Marks when rx_d holds a genuine line sample rather than a reset-forced 1,
  // so a line that is already low at reset release cannot fake a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_ok <= '0;
    end else begin
      line_ok <= {line_ok[1:0], 1'b1};
    end
  end

  assign start_edge = (state == IDLE) && line_ok[2] && !rx_s && rx_d;
  assign sample     = (phase == PW'(SAMPLE_POINT));
  assign last_bit   = (bit_idx == IW'(DATA_BITS - 1));
  assign busy       = (state != IDLE);

  bit_phase_counter #(
    .N(BIT_CLKS)
  ) u_phase (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .run   (run),
    .phase (phase),
    .wrap  (wrap)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and phase-counter control.
  always_comb begin
    state_nxt   = state;
    clear       = 1'b0;
    run         = 1'b1;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        run   = start_edge;
        clear = !start_edge;
        if (start_edge) state_nxt = START;
      end
      START: begin
        if (sample) begin
          if (rx_s) begin
            state_nxt = IDLE;
            clear     = 1'b1;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (sample && last_bit) state_nxt = STOP;
      end
      STOP: begin
        if (sample) begin
          state_nxt   = IDLE;
          clear       = 1'b1;
          stop_sample = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data shift register (LSB arrives first, enters at the MSB end) and bit index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if ((state == DATA) && sample) begin
      shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
      bit_idx <= last_bit ? '0 : bit_idx + IW'(1);
    end
  end

  // Registered stop-bit result: publish the word or flag a framing error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= stop_sample && rx_s;
      frame_error <= stop_sample && !rx_s;
      if (stop_sample && rx_s) rx_data <= shreg;
    end
  end

  // The phase counter only reaches its wrap point mid-frame.
  assert property (@(posedge clk) disable iff (!reset) wrap |-> busy);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: timestamp-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized frames.
module tb_serial_frame_receiver;

  localparam int BC = 100;
  localparam int DB = 8;
  localparam int SP = 50;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          rx_in = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_error, busy;

  serial_frame_receiver #(
    .BIT_CLKS    (BC),
    .DATA_BITS   (DB),
    .SAMPLE_POINT(SP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // ---------------- reference model (frame timestamps) ----------------
  // The receiver sees rx_in two edges late; a frame starting at edge cycle E is
  // sampled at E+SP+k*BC (k=0 start, 1..DB data, DB+1 stop), result one cycle later.
  logic          s1m = 1'b1, rxs = 1'b1, prev_rxs = 1'b1;
  int            since_rel = 0;
  int            fstart = -1, fend = -1, k, b;
  logic [DB-1:0] m_word = '0, pend_w = '0, exp_data = '0;
  logic          pend_v = 1'b0, pend_e = 1'b0;
  logic          exp_valid = 1'b0, exp_ferr = 1'b0, exp_busy = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    if (!reset) begin
      s1m = 1'b1; rxs = 1'b1; prev_rxs = 1'b1; since_rel = 0;
      fstart = -1; fend = -1; pend_v = 1'b0; pend_e = 1'b0; exp_data = '0;
    end else begin
      since_rel = since_rel + 1;
      prev_rxs = rxs; rxs = s1m; s1m = rx_in;
      if (pend_v) begin exp_valid = 1'b1; exp_data = pend_w; end
      exp_ferr = pend_e;
      pend_v = 1'b0; pend_e = 1'b0;
      if (fstart >= 0 && cyc > fstart && cyc <= fend) begin
        k = cyc - fstart - SP;
        if (k >= 0 && k % BC == 0) begin
          b = k / BC;
          if (b == 0) begin
            if (rxs) fend = cyc;
          end else if (b <= DB) begin
            m_word[b-1] = rxs;
          end else begin
            fend = cyc;
            if (rxs) begin pend_v = 1'b1; pend_w = m_word; end
            else pend_e = 1'b1;
          end
        end
      end else if (since_rel >= 3 && !rxs && prev_rxs) begin
        fstart = cyc;
        fend   = 32'h3fff_ffff;
      end
    end
    exp_busy = (fstart >= 0) && (cyc > fstart) && (cyc <= fend);
  end

  // ---------------- per-cycle compare and event monitor ----------------
  logic [DB-1:0] vq_data[$];
  int            vq_cyc[$];
  int            n_ferr = 0, n_busy = 0, m_vcyc = -1;

  always @(posedge clk) begin
    #1;
    chk("outputs {busy,valid,ferr,data}",
        32'({busy, rx_valid, frame_error, rx_data}),
        32'({exp_busy, exp_valid, exp_ferr, exp_data}));
    if (rx_valid) begin
      vq_data.push_back(rx_data);
      vq_cyc.push_back(cyc);
    end
    if (frame_error) n_ferr++;
    if (busy) n_busy++;
    if (exp_valid) m_vcyc = cyc;
  end

  function automatic logic [31:0] vdata(input int i);
    return (i < vq_data.size()) ? 32'(vq_data[i]) : 32'hdead;
  endfunction

  function automatic logic [31:0] vcyc(input int i);
    return (i < vq_cyc.size()) ? 32'(vq_cyc[i]) : 32'hdead;
  endfunction

  // Drives one frame starting at the current negedge; each bit held bc clocks.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int bc,
                            output int fall);
    rx_in = 1'b0;
    fall  = cyc;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx_in = d[i];
      repeat (bc) @(negedge clk);
    end
    rx_in = stop;
    repeat (bc) @(negedge clk);
    rx_in = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int fall, fall2, f_bg, v0, e0, nb;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset valid/err", 32'({rx_valid, frame_error}), 0);
    chk("reset data", 32'(rx_data), 0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // 1: single frame 0xA5
    v0 = vq_data.size(); e0 = n_ferr;
    send_frame(8'hA5, 1'b1, BC, fall);
    repeat (10) @(negedge clk);
    chk("t1 valid count", 32'(vq_data.size() - v0), 1);
    chk("t1 data", vdata(v0), 32'h A5);
    chk("t1 latency", vcyc(v0), 32'(fall + 953));
    chk("t1 model latency", 32'(m_vcyc), 32'(fall + 953));
    chk("t1 no frame_error", 32'(n_ferr - e0), 0);

    // 2: back-to-back 0x00, 0xFF
    v0 = vq_data.size();
    send_frame(8'h00, 1'b1, BC, fall);
    send_frame(8'hFF, 1'b1, BC, fall2);
    repeat (10) @(negedge clk);
    chk("t2 valid count", 32'(vq_data.size() - v0), 2);
    chk("t2 first data", vdata(v0), 32'h00);
    chk("t2 second data", vdata(v0 + 1), 32'hFF);
    chk("t2 spacing", vcyc(v0 + 1) - vcyc(v0), 1000);

    // 3: 20-clk glitch -> false start
    v0 = vq_data.size(); e0 = n_ferr; nb = n_busy;
    rx_in = 1'b0;
    repeat (20) @(negedge clk);
    rx_in = 1'b1;
    repeat (100) @(negedge clk);
    chk("t3 busy cycles", 32'(n_busy - nb), 50);
    chk("t3 no pulses", 32'((vq_data.size() - v0) + (n_ferr - e0)), 0);

    // 4: bad stop bit, then a good frame
    v0 = vq_data.size(); e0 = n_ferr;
    send_frame(8'h3C, 1'b0, BC, fall);
    repeat (5) @(negedge clk);
    chk("t4 frame_error count", 32'(n_ferr - e0), 1);
    chk("t4 no valid", 32'(vq_data.size() - v0), 0);
    chk("t4 data held", 32'(rx_data), 32'hFF);
    send_frame(8'h11, 1'b1, BC, fall);
    repeat (10) @(negedge clk);
    chk("t4 good data", vdata(v0), 32'h11);

    // 5: reset during data bit 4
    v0 = vq_data.size(); e0 = n_ferr;
    fork
      send_frame(8'hF3, 1'b1, BC, f_bg);
    join_none
    repeat (550) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5 outputs cleared", 32'({busy, rx_valid, frame_error, rx_data}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait fork;
    repeat (20) @(negedge clk);
    chk("t5 no pulse for aborted frame", 32'((vq_data.size() - v0) + (n_ferr - e0)), 0);
    send_frame(8'h5A, 1'b1, BC, fall);
    repeat (10) @(negedge clk);
    chk("t5 next frame data", vdata(v0), 32'h5A);

    // 6: line low through reset release
    reset = 1'b0; rx_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    v0 = vq_data.size(); e0 = n_ferr; nb = n_busy;
    repeat (500) @(negedge clk);
    rx_in = 1'b1;
    repeat (300) @(negedge clk);
    chk("t6 quiet busy", 32'(n_busy - nb), 0);
    chk("t6 quiet pulses", 32'((vq_data.size() - v0) + (n_ferr - e0)), 0);
    send_frame(8'hC3, 1'b1, BC, fall);
    repeat (10) @(negedge clk);
    chk("t6 data", vdata(v0), 32'hC3);
    chk("t6 latency", vcyc(v0), 32'(fall + 953));

    // Randomized frames: jittered bit length, occasional glitches and bad stop bits
    for (int f = 0; f < 14; f++) begin
      automatic int            gap  = $urandom_range(40, 1);
      automatic int            bc   = $urandom_range(104, 96);
      automatic logic [DB-1:0] d    = DB'($urandom);
      automatic logic          stop = ($urandom_range(5, 0) != 0);
      if ($urandom_range(3, 0) == 0) begin
        rx_in = 1'b0;
        repeat ($urandom_range(30, 3)) @(negedge clk);
        rx_in = 1'b1;
        repeat (60) @(negedge clk);
      end
      repeat (gap) @(negedge clk);
      send_frame(d, stop, bc, fall);
    end
    repeat (30) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
